// File: rtl/ysyx_ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute
// redirect, and the {pc, inst} output channel toward decode/execute.
interface ysyx_ifu_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  // Fetch unit side
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst
  );

  // Memory / execute / downstream side
  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst
  );
endinterface

// File: rtl/ysyx_ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one imem read at a time,
// presents {pc, inst} downstream, and squashes work on execute redirects.
// Every output is a register; no input reaches an output combinationally.
module ysyx_ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  ysyx_ifu_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_inst_q, out_inst_d;

  logic [XLEN-1:0] redirect_tgt;
  logic            req_hs;
  logic            out_hs;

  assign redirect_tgt = bus.redirect_pc & ALIGN_MASK;
  assign req_hs       = req_valid_q & bus.imem_req_ready;
  assign out_hs       = out_valid_q & bus.out_ready;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  // Next-state logic: request, wait for response, hold for downstream
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;

    unique case (state_q)
      ST_REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
        end
        if (req_hs) begin
          state_d = ST_WAIT;
          // A redirect racing the handshake leaves a response for the old
          // address in flight; mark it for discard.
          drop_d  = bus.redirect_valid;
        end
      end

      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop_q || bus.redirect_valid) begin
            if (bus.redirect_valid) begin
              pc_d = redirect_tgt;
            end
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            out_inst_d  = bus.imem_rsp_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end else if (bus.redirect_valid) begin
          pc_d   = redirect_tgt;
          drop_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d        = redirect_tgt;
          out_valid_d = 1'b0;
          state_d     = ST_REQ;
        end else if (out_hs) begin
          pc_d        = pc_q + INST_BYTES;
          out_valid_d = 1'b0;
          state_d     = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    // Request valid is registered from the next state so it never depends
    // on this cycle's inputs, and it stays low while reset is held.
    req_valid_d = (state_d == ST_REQ);
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_inst       = out_inst_q;

endmodule

// File: tb/tb_ysyx_ifu_fetch.sv
// Bench for ysyx_ifu_fetch: directed scenarios plus randomized traffic,
// checked against an instruction-stream reference (expected next PC).
module tb_ysyx_ifu_fetch;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;

  always #5 clk = ~clk;

  ysyx_ifu_fetch_if #(.XLEN(32)) bus ();
  ysyx_ifu_fetch_if #(.XLEN(32)) bus_b ();

  ysyx_ifu_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ysyx_ifu_fetch #(.XLEN(32), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state: the PC the next request / delivery must carry
  logic [31:0] exp_pc;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          mem_delay;
  int          cyc;
  int          hs_cnt, dlv_cnt;
  int          last_hs_cyc, last_dlv_cyc;
  logic [31:0] last_dlv_pc;
  bit          prev_stall;
  logic [31:0] prev_pc, prev_inst;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the edge, check outputs at the falling edge
  task automatic tick(input bit rdy, input bit ordy, input bit redir,
                      input logic [31:0] tgt, input bit stale);
    @(posedge clk);
    #1;
    bus.imem_req_ready = rdy;
    bus.out_ready      = ordy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (stale) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pend_cnt == 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memfn(pend_addr);
      pend_cnt = 0;
    end else if (pend_cnt > 1) begin
      pend_cnt--;
    end
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_pc", bus.out_pc, prev_pc);
      check_eq("hold_inst", bus.out_inst, prev_inst);
    end
    check_eq("req_out_excl", 32'(bus.imem_req_valid & bus.out_valid), 32'd0);
    if (bus.imem_req_valid && rdy) begin
      check_eq("req_addr", bus.imem_req_addr, exp_pc);
      hs_cnt++;
      last_hs_cyc = cyc;
      pend_addr   = bus.imem_req_addr;
      pend_cnt    = mem_delay;
    end
    if (bus.out_valid && ordy) begin
      check_eq("out_pc", bus.out_pc, exp_pc);
      check_eq("out_inst", bus.out_inst, memfn(exp_pc));
      dlv_cnt++;
      last_dlv_cyc = cyc;
      last_dlv_pc  = bus.out_pc;
      exp_pc       = exp_pc + 32'd4;
    end
    if (redir) exp_pc = tgt & ~32'h3;
    prev_stall = bus.out_valid && !ordy && !redir;
    prev_pc    = bus.out_pc;
    prev_inst  = bus.out_inst;
  endtask

  // Asynchronous reset pulse landing between clock edges
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_pc", bus.out_pc, 32'd0);
    check_eq("rst_out_inst", bus.out_inst, 32'd0);
    check_eq("rst_req_addr", bus.imem_req_addr, RST_PC);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc     = RST_PC;
    pend_cnt   = 0;
    prev_stall = 1'b0;
  endtask

  logic [31:0] b_q[$];
  bit          b_pend;
  logic [31:0] b_addr;
  int          dlv_mark, hs_mark, guard;

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    bus_b.imem_req_ready = 1'b1; bus_b.imem_rsp_valid = 1'b0; bus_b.imem_rsp_data = '0;
    bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0; bus_b.out_ready = 1'b1;
    cyc = 0; hs_cnt = 0; dlv_cnt = 0; last_hs_cyc = -1; last_dlv_cyc = -1;
    last_dlv_pc = '0; mem_delay = 1; pend_cnt = 0; exp_pc = RST_PC; prev_stall = 1'b0;

    // Full-rate streaming: one instruction every three cycles
    do_reset();
    hs_mark = hs_cnt; dlv_mark = dlv_cnt;
    for (int i = 0; i < 9; i++) tick(1, 1, 0, '0, 0);
    check_eq("stream_reqs", 32'(hs_cnt - hs_mark), 32'd3);
    check_eq("stream_dlvs", 32'(dlv_cnt - dlv_mark), 32'd3);
    check_eq("stream_last_pc", last_dlv_pc, 32'h8000_0008);

    // Downstream backpressure while holding pc 0x80000004
    do_reset();
    dlv_mark = dlv_cnt;
    guard = 0;
    while (dlv_cnt == dlv_mark && guard < 20) begin tick(1, 1, 0, '0, 0); guard++; end
    guard = 0;
    tick(1, 0, 0, '0, 0);
    while (!bus.out_valid && guard < 20) begin tick(1, 0, 0, '0, 0); guard++; end
    check_eq("bp_pc", bus.out_pc, 32'h8000_0004);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    check_eq("bp_next_req", 32'(last_hs_cyc - last_dlv_cyc), 32'd1);

    // Redirect while waiting on a slow response
    do_reset();
    mem_delay = 3;
    hs_mark = hs_cnt; guard = 0;
    while (hs_cnt == hs_mark && guard < 20) begin tick(1, 1, 0, '0, 0); guard++; end
    tick(1, 1, 1, 32'h8000_1002, 0);
    dlv_mark = dlv_cnt; guard = 0;
    while (dlv_cnt == dlv_mark && guard < 30) begin tick(1, 1, 0, '0, 0); guard++; end
    check_eq("wait_redir_pc", last_dlv_pc, 32'h8000_1000);

    // Redirect coincident with output handshake in HOLD
    mem_delay = 1; guard = 0;
    tick(1, 0, 0, '0, 0);
    while (!bus.out_valid && guard < 20) begin tick(1, 0, 0, '0, 0); guard++; end
    dlv_mark = dlv_cnt;
    tick(1, 1, 1, 32'h8000_0100, 0);
    check_eq("hold_redir_count", 32'(dlv_cnt - dlv_mark), 32'd1);
    tick(0, 1, 0, '0, 0);
    check_eq("hold_redir_clear", 32'(bus.out_valid), 32'd0);
    check_eq("hold_redir_addr", bus.imem_req_addr, 32'h8000_0100);

    // Redirect racing a request handshake in REQ
    guard = 0;
    while (!bus.imem_req_valid && guard < 20) begin tick(0, 1, 0, '0, 0); guard++; end
    dlv_mark = dlv_cnt;
    tick(1, 1, 1, 32'h8000_200B, 0);
    guard = 0;
    while (dlv_cnt == dlv_mark && guard < 30) begin tick(1, 1, 0, '0, 0); guard++; end
    check_eq("req_redir_pc", last_dlv_pc, 32'h8000_2008);

    // Reset mid-WAIT followed by a stale response
    mem_delay = 3; hs_mark = hs_cnt; guard = 0;
    while (hs_cnt == hs_mark && guard < 20) begin tick(1, 1, 0, '0, 0); guard++; end
    do_reset();
    mem_delay = 1;
    tick(0, 1, 0, '0, 1);
    check_eq("stale_out_valid", 32'(bus.out_valid), 32'd0);
    dlv_mark = dlv_cnt; guard = 0;
    while (dlv_cnt == dlv_mark && guard < 20) begin tick(1, 1, 0, '0, 0); guard++; end
    check_eq("stale_first_pc", last_dlv_pc, RST_PC);

    // Randomized traffic
    dlv_mark = dlv_cnt;
    for (int i = 0; i < 3000; i++) begin
      mem_delay = int'($urandom_range(1, 3));
      tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) < 8), {16'h8000, 16'($urandom)}, 0);
    end
    check_eq("rand_progress", 32'(dlv_cnt - dlv_mark > 50), 32'd1);

    // PC wrap from 0xFFFFFFFC on the second instance
    b_pend = 1'b0; b_addr = '0;
    @(posedge clk); #1; rst_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      bus_b.imem_rsp_valid = b_pend;
      bus_b.imem_rsp_data  = memfn(b_addr);
      b_pend = 1'b0;
      @(negedge clk);
      if (bus_b.imem_req_valid) begin b_pend = 1'b1; b_addr = bus_b.imem_req_addr; end
      if (bus_b.out_valid) begin
        b_q.push_back(bus_b.out_pc);
        check_eq("wrap_inst", bus_b.out_inst, memfn(bus_b.out_pc));
      end
    end
    check_eq("wrap_count", 32'(b_q.size() >= 3), 32'd1);
    if (b_q.size() >= 3) begin
      check_eq("wrap_pc0", b_q[0], 32'hFFFF_FFFC);
      check_eq("wrap_pc1", b_q[1], 32'h0000_0000);
      check_eq("wrap_pc2", b_q[2], 32'h0000_0004);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
